// File: rtl/gol_pkg.sv
// Shared types and the neighbour-count helper for the Game of Life generation engine.
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    COPY    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int NBR_W     = 4;
  localparam int MAX_WIDTH = 64;

  // Rows arrive zero-extended to MAX_WIDTH; only the low 'width' bits are live,
  // so column wrap is computed against 'width' rather than MAX_WIDTH.
  function automatic logic [NBR_W-1:0] count_nbrs(
    input logic [MAX_WIDTH-1:0] above,
    input logic [MAX_WIDTH-1:0] cur,
    input logic [MAX_WIDTH-1:0] below,
    input int                   c,
    input int                   width
  );
    logic [NBR_W-1:0] n;
    int               lft;
    int               rgt;
    lft = (c == width - 1) ? 0 : c + 1;
    rgt = (c == 0) ? width - 1 : c - 1;
    n = '0;
    n = n + NBR_W'(above[lft]) + NBR_W'(above[c]) + NBR_W'(above[rgt]);
    n = n + NBR_W'(cur[lft])                     + NBR_W'(cur[rgt]);
    n = n + NBR_W'(below[lft]) + NBR_W'(below[c]) + NBR_W'(below[rgt]);
    return n;
  endfunction

endpackage

// File: rtl/gol_row_rule.sv
// Combinational next-row rule: birth on 3 neighbours, survival on 2 or 3,
// with toroidal column wrap.
module gol_row_rule
  import gol_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  output logic [WIDTH-1:0] next_row
);

  logic [MAX_WIDTH-1:0] above_x;
  logic [MAX_WIDTH-1:0] cur_x;
  logic [MAX_WIDTH-1:0] below_x;
  logic [NBR_W-1:0]     n;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    above_x  = '0;
    cur_x    = '0;
    below_x  = '0;
    n        = '0;
    next_row = '0;
    above_x[WIDTH-1:0] = above;
    cur_x[WIDTH-1:0]   = cur;
    below_x[WIDTH-1:0] = below;
    for (int c = 0; c < WIDTH; c++) begin
      n = count_nbrs(above_x, cur_x, below_x, c, WIDTH);
      next_row[c] = (n == NBR_W'(3)) | (cur[c] & (n == NBR_W'(2)));
    end
  end

endmodule

// File: rtl/gol_gen_engine.sv
// Generation sequencer: reads every row through a one-cycle stage register,
// buffers the next generation, then copies it back into the register file.
module gol_gen_engine
  import gol_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16
) (
  input  logic               ph1,
  input  logic               reset,
  input  logic               start,
  output logic [REGBITS-1:0] ra,
  input  logic [WIDTH-1:0]   rd1,
  input  logic [WIDTH-1:0]   rd2,
  input  logic [WIDTH-1:0]   rd3,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd,
  output logic               busy,
  output logic               done,
  output logic [GENBITS-1:0] gen
);

  localparam int N    = 1 << REGBITS;
  localparam int CNTW = REGBITS + 1;
  localparam logic [CNTW-1:0] LAST_ROW    = CNTW'(N - 1);
  localparam logic [CNTW-1:0] COMPUTE_END = CNTW'(N);

  state_t             state;
  state_t             next_state;
  logic [CNTW-1:0]    cnt;
  logic [WIDTH-1:0]   stg_above;
  logic [WIDTH-1:0]   stg_cur;
  logic [WIDTH-1:0]   stg_below;
  logic [REGBITS-1:0] stg_tag;
  logic [WIDTH-1:0]   next_row;
  logic [REGBITS-1:0] wa_inc;
  logic [WIDTH-1:0]   buffer [N];

  assign wa_inc = wa + 1'b1;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COMPUTE;
      COMPUTE: if (cnt == COMPUTE_END) next_state = COPY;
      COPY:    if (cnt == LAST_ROW) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  gol_row_rule #(.WIDTH(WIDTH)) u_rule (
    .above    (stg_above),
    .cur      (stg_cur),
    .below    (stg_below),
    .next_row (next_row)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ra        <= '0;
      regwrite  <= 1'b0;
      wa        <= '0;
      wd        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gen       <= '0;
      stg_above <= '0;
      stg_cur   <= '0;
      stg_below <= '0;
      stg_tag   <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= (next_state == DONE);
      cnt   <= (state == IDLE || state != next_state) ? '0 : cnt + 1'b1;

      if (state == DONE) gen <= gen + 1'b1;

      // Row k is staged at the end of cycle k; the rule consumes it one cycle later.
      if (state == COMPUTE && cnt < COMPUTE_END) begin
        stg_above <= rd1;
        stg_cur   <= rd2;
        stg_below <= rd3;
        stg_tag   <= cnt[REGBITS-1:0];
      end

      if (state == COMPUTE) begin
        if (cnt < LAST_ROW)          ra <= ra + 1'b1;
        else if (cnt == COMPUTE_END) ra <= '0;
      end else begin
        ra <= '0;
      end

      if (state == COMPUTE && next_state == COPY) begin
        regwrite <= 1'b1;
        wa       <= '0;
        wd       <= buffer[0];
      end else if (state == COPY && next_state == COPY) begin
        wa <= wa_inc;
        wd <= buffer[wa_inc];
      end else begin
        regwrite <= 1'b0;
        wa       <= '0;
        wd       <= '0;
      end
    end
  end

  // NOTE: the next-state buffer has no reset; it is always fully rewritten
  // during COMPUTE before COPY reads it.
  always_ff @(posedge ph1) begin
    if (state == COMPUTE && cnt != '0) buffer[stg_tag] <= next_row;
  end

endmodule

// File: tb/tb_gol_gen_engine.sv
// Directed bench for gol_gen_engine with a behavioural register file and a
// scoreboard of expected write-back beats.
module tb_gol_gen_engine;

  localparam int WIDTH   = 8;
  localparam int REGBITS = 3;
  localparam int GENBITS = 16;
  localparam int N       = 8;

  typedef logic [WIDTH-1:0] board_t [N];

  typedef struct {
    logic [REGBITS-1:0] addr;
    logic [WIDTH-1:0]   data;
  } beat_t;

  logic               ph1 = 1'b0;
  logic               reset;
  logic               start;
  logic [REGBITS-1:0] ra;
  logic [WIDTH-1:0]   rd1, rd2, rd3;
  logic               regwrite;
  logic [REGBITS-1:0] wa;
  logic [WIDTH-1:0]   wd;
  logic               busy;
  logic               done;
  logic [GENBITS-1:0] gen;

  logic [WIDTH-1:0] mem [N];
  board_t           load_board;
  logic             load_en;
  beat_t            sb_q [$];
  int               n_checks;
  int               n_fails;
  logic [GENBITS-1:0] exp_gen;

  always #5 ph1 = ~ph1;

  gol_gen_engine #(.WIDTH(WIDTH), .REGBITS(REGBITS), .GENBITS(GENBITS)) dut (
    .ph1      (ph1),
    .reset    (reset),
    .start    (start),
    .ra       (ra),
    .rd1      (rd1),
    .rd2      (rd2),
    .rd3      (rd3),
    .regwrite (regwrite),
    .wa       (wa),
    .wd       (wd),
    .busy     (busy),
    .done     (done),
    .gen      (gen)
  );

  // Register file model with modulo row addressing.
  assign rd1 = mem[ra - 3'd1];
  assign rd2 = mem[ra];
  assign rd3 = mem[ra + 3'd1];

  always @(posedge ph1) begin
    if (load_en) begin
      for (int i = 0; i < N; i++) mem[i] <= load_board[i];
    end else if (regwrite) begin
      mem[wa] <= wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input board_t b);
    @(negedge ph1);
    load_board = b;
    load_en    = 1'b1;
    @(negedge ph1);
    load_en    = 1'b0;
  endtask

  task automatic check_board(input string tag, input board_t b);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_row%0d", tag, i), 32'(mem[i]), 32'(b[i]));
  endtask

  // One generation: scoreboard gets the expected write-back beats, then each
  // cycle 1..20 after the start edge is checked for timing and write data.
  task automatic run_gen(input string tag, input board_t exp_b, input bit repulse);
    beat_t bt;
    for (int i = 0; i < N; i++) begin
      bt.addr = REGBITS'(i);
      bt.data = exp_b[i];
      sb_q.push_back(bt);
    end
    @(negedge ph1);
    start = 1'b1;
    @(negedge ph1);
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      check($sformatf("%s_busy_c%0d", tag, cyc), 32'(busy), 32'(cyc <= 18));
      check($sformatf("%s_done_c%0d", tag, cyc), 32'(done), 32'(cyc == 18));
      check($sformatf("%s_regwrite_c%0d", tag, cyc), 32'(regwrite), 32'(cyc >= 10 && cyc <= 17));
      if (cyc <= 8)  check($sformatf("%s_ra_c%0d", tag, cyc), 32'(ra), 32'(cyc - 1));
      if (cyc >= 19) check($sformatf("%s_ra_idle_c%0d", tag, cyc), 32'(ra), 32'(0));
      if (regwrite === 1'b1) begin
        if (sb_q.size() == 0) begin
          check($sformatf("%s_extra_write_c%0d", tag, cyc), 32'(1), 32'(0));
        end else begin
          bt = sb_q.pop_front();
          check($sformatf("%s_wa_c%0d", tag, cyc), 32'(wa), 32'(bt.addr));
          check($sformatf("%s_wd_c%0d", tag, cyc), 32'(wd), 32'(bt.data));
        end
      end
      start = (repulse && cyc == 5);
      @(negedge ph1);
    end
    start = 1'b0;
    check($sformatf("%s_sb_empty", tag), 32'(sb_q.size()), 32'(0));
    sb_q.delete();
    exp_gen = exp_gen + 1'b1;
    check($sformatf("%s_gen", tag), 32'(gen), 32'(exp_gen));
    check_board(tag, exp_b);
  endtask

  board_t blinker_v, blinker_h, block_b, wrap_in, wrap_out, empty_b;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    exp_gen  = '0;
    load_en  = 1'b0;
    start    = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < N; i++) begin
      blinker_v[i] = '0; blinker_h[i] = '0; block_b[i] = '0;
      wrap_in[i]   = '0; wrap_out[i]  = '0; empty_b[i] = '0;
      mem[i]       = '0;
    end
    blinker_v[2] = 8'h08; blinker_v[3] = 8'h08; blinker_v[4] = 8'h08;
    blinker_h[3] = 8'h1C;
    block_b[1]   = 8'h18; block_b[2]   = 8'h18;
    wrap_in[0]   = 8'h83;
    wrap_out[7]  = 8'h01; wrap_out[0]  = 8'h01; wrap_out[1] = 8'h01;

    #12;
    check("rst_ra",       32'(ra),       32'(0));
    check("rst_regwrite", 32'(regwrite), 32'(0));
    check("rst_wa",       32'(wa),       32'(0));
    check("rst_wd",       32'(wd),       32'(0));
    check("rst_busy",     32'(busy),     32'(0));
    check("rst_done",     32'(done),     32'(0));
    check("rst_gen",      32'(gen),      32'(0));
    @(negedge ph1);
    reset = 1'b1;

    load(blinker_v);
    run_gen("blink1", blinker_h, 1'b0);
    run_gen("blink2", blinker_v, 1'b1);

    load(block_b);
    run_gen("still", block_b, 1'b0);

    load(wrap_in);
    run_gen("wrap", wrap_out, 1'b0);

    // Abort during COPY: outputs must drop asynchronously, before any edge.
    load(blinker_v);
    @(negedge ph1);
    start = 1'b1;
    @(negedge ph1);
    start = 1'b0;
    repeat (11) @(negedge ph1);
    check("abort_in_copy", 32'(regwrite), 32'(1));
    #2;
    reset = 1'b0;
    #1;
    check("abort_regwrite", 32'(regwrite), 32'(0));
    check("abort_busy",     32'(busy),     32'(0));
    check("abort_gen",      32'(gen),      32'(0));
    check("abort_done",     32'(done),     32'(0));
    exp_gen = '0;
    @(negedge ph1);
    reset = 1'b1;

    load(empty_b);
    run_gen("empty1", empty_b, 1'b0);
    run_gen("empty2", empty_b, 1'b0);
    run_gen("empty3", empty_b, 1'b0);
    check("empty_gen3", 32'(gen), 32'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gol_gen_engine.md
Name: gol_gen_engine

Overview:
- Generation sequencer for the Game of Life datapath; sits directly downstream of the previous-state row register file (8x8 default).
- Drives the row read address and consumes the three combinational row outputs: row above, current row, row below.
- Computes each next-generation row and holds it in an internal next-state buffer.
- After all rows are computed, writes the buffer back into the register file through its write port, then signals completion.

Parameters:
- WIDTH, 8, cells per row, which is the register file row width.
- REGBITS, 3, row address bits; the board has N = 2**REGBITS rows.
- GENBITS, 16, width of the generation counter.

Ports:
- ph1  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request one generation step; sampled only in IDLE.
- ra  out  REGBITS  row read address to the register file.
- rd1  in  WIDTH  row ra-1, modulo N.
- rd2  in  WIDTH  row ra.
- rd3  in  WIDTH  row ra+1, modulo N.
- regwrite  out  1  register file write enable.
- wa  out  REGBITS  register file write address.
- wd  out  WIDTH  register file write data.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when a generation is committed.
- gen  out  GENBITS  count of committed generations.

Behaviour:
- Reset values (asynchronous, while reset=0): state=IDLE, ra=0, regwrite=0, wa=0, wd=0, busy=0, done=0, gen=0. The next-state buffer is not reset; its contents are don't-care.
- Reset mid-operation aborts immediately. A partial COPY leaves the register file holding mixed generations; this is accepted.
- States: IDLE, COMPUTE, COPY, DONE.
- IDLE:
  - ra=0, regwrite=0.
  - start=1 at an edge moves to COMPUTE with row counter r=0.
  - start is ignored in every other state.
- COMPUTE runs N+1 cycles:
  - Cycle k (0..N-1) drives ra=k. At the end of cycle k, rd1/rd2/rd3 are registered into the stage register together with tag k.
  - Cycle k+1 (1..N) computes the next row from the staged rows and writes it to buffer[k] at the end of that cycle.
  - In cycle N, ra holds N-1 and is a don't-care.
  - After cycle N, move to COPY with i=0.
  - Only registered rows are used, so read-address-to-data latency is 1 cycle.
- COPY runs N cycles: regwrite=1, wa=i, wd=buffer[i] for i=0..N-1, all registered outputs. After i=N-1, regwrite drops and the state moves to DONE.
- DONE runs 1 cycle: done=1, gen increments by 1 (wraps modulo 2**GENBITS), then the state moves to IDLE. busy falls on entry to IDLE.
- Total latency: the start edge is followed by 2N+2 busy cycles. done is asserted in the last of them, cycle 18 for N=8.
- Next-row rule, per bit c:
  - Neighbours are bits c-1, c, c+1 of the above and below rows, plus bits c-1 and c+1 of the current row.
  - Columns wrap toroidally: bit WIDTH-1 and bit 0 are adjacent.
  - Rows wrap through the register file's modulo addressing.
  - Count range is 0..8, held in 4 bits.
  - next = (count==3) | (cur[c] & count==2).
- Invariant: the register file is never written during COMPUTE, so every row is computed from the old generation only.

Decomposition:
- gol_pkg holds:
  - state_t enum {IDLE, COMPUTE, COPY, DONE};
  - NBR_W=4 localparam;
  - a function count_nbrs(above, cur, below, c) with toroidal column indexing.
- One sub-module, gol_row_rule: purely combinational, above/cur/below to next row, parameterised by WIDTH. Instantiated once on the stage register outputs.

Test Plan:
- Blinker: rows 2,3,4 = 8'h08 and all others 0, then start. After done: row3=8'h1C, all others 0, gen=1. A second start restores the original rows, gen=2.
- Still life: rows 1,2 = 8'h18, others 0, then start. Board unchanged after done; regwrite high for exactly 8 cycles with wa=0..7 in order.
- Double wrap: row0 = 8'h83, others 0, then start. After done: rows 7,0,1 = 8'h01, all others 0.
- Timing: start pulse at edge 0. Checks:
  - busy=1 from cycle 1 to cycle 18;
  - ra steps 0..7 in cycles 1..8;
  - regwrite=1 in cycles 10..17;
  - done=1 only in cycle 18;
  - start re-pulsed in cycle 5 is ignored, and gen increases by exactly 1.
- Reset abort: assert reset in cycle 12 (during COPY). Checks:
  - regwrite=0 and busy=0 immediately, without waiting for a clock;
  - gen=0;
  - after release, a new start completes normally with correct timing.
- Empty board: all rows 0, 3 consecutive generations. All rows stay 0 and gen=3.
